// File: rtl/timer_alarm_ctrl_if.sv
// Alarm pin bundle: timer/button inputs and piezo/LED/busy outputs.
interface timer_alarm_ctrl_if;
    logic S;
    logic STOP;
    logic PIEZO;
    logic LED;
    logic BUSY;

    modport master (
        output S,
        output STOP,
        input  PIEZO,
        input  LED,
        input  BUSY
    );

    modport slave (
        input  S,
        input  STOP,
        output PIEZO,
        output LED,
        output BUSY
    );
endinterface

// File: rtl/timer_alarm_ctrl.sv
// Alarm beeper: beep/gap bursts with pause, stop and optional ring timeout.
// Optional feature macro: ALARM_TIMEOUT_EN (ring timeout of TIMEOUT_S seconds).
module timer_alarm_ctrl #(
    parameter int TONE_HALF = 1,
    parameter int BEEP_MS   = 200,
    parameter int GAP_MS    = 100,
    parameter int BEEPS     = 4,
    parameter int PAUSE_MS  = 500,
    parameter int TIMEOUT_S = 30
) (
    input  logic              CLK,
    input  logic              RESETN,
    timer_alarm_ctrl_if.slave bus
);

    localparam int BG_MAX = (BEEP_MS > GAP_MS) ? BEEP_MS : GAP_MS;
    localparam int PH_MAX = (BG_MAX > PAUSE_MS) ? BG_MAX : PAUSE_MS;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int BC_W   = $clog2(BEEPS + 1);
    localparam int TN_W   = $clog2(TONE_HALF + 1);

    typedef enum logic [1:0] {
        IDLE,
        BEEP,
        GAP,
        PAUSE
    } state_t;

    state_t state;
    state_t state_n;

    logic            s_d;
    logic            stop_d;
    logic            s_start;
    logic            stop_en;
    logic [PH_W-1:0] ph_cnt;
    logic [BC_W-1:0] beep_cnt;
    logic [TN_W-1:0] tone_cnt;
    logic            beep_inc;
    logic            beep_clr;
    logic            to_hit;
    logic            piezo;
    logic            led;
    logic            busy;

    assign s_start = bus.S & ~s_d;
    assign stop_en = bus.STOP & ~stop_d;

`ifdef ALARM_TIMEOUT_EN
    localparam int TO_MAX = TIMEOUT_S * 1000;
    localparam int TO_W   = $clog2(TO_MAX + 1);

    logic [TO_W-1:0] to_cnt;

    assign to_hit = (state != IDLE) && (to_cnt == TO_W'(TO_MAX - 1));

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_n  = state;
        beep_inc = 1'b0;
        beep_clr = 1'b0;
        case (state)
            IDLE: begin
                if (s_start && !stop_en) state_n = BEEP;
            end
            BEEP: begin
                if (ph_cnt == PH_W'(BEEP_MS - 1)) begin
                    state_n  = GAP;
                    beep_inc = 1'b1;
                end
            end
            GAP: begin
                if (ph_cnt == PH_W'(GAP_MS - 1)) begin
                    if (beep_cnt < BC_W'(BEEPS)) begin
                        state_n = BEEP;
                    end else begin
                        state_n  = PAUSE;
                        beep_clr = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (ph_cnt == PH_W'(PAUSE_MS - 1)) state_n = BEEP;
            end
            default: state_n = IDLE;
        endcase
        // Abort has priority over every sequencing transition.
        if (state != IDLE && (stop_en || !bus.S || to_hit)) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= IDLE;
            s_d      <= 1'b0;
            stop_d   <= 1'b0;
            ph_cnt   <= '0;
            beep_cnt <= '0;
            tone_cnt <= '0;
            piezo    <= 1'b0;
            led      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state  <= state_n;
            s_d    <= bus.S;
            stop_d <= bus.STOP;

            if (state_n != state || state == IDLE) begin
                ph_cnt <= '0;
            end else begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end

            if (state == IDLE || beep_clr) begin
                beep_cnt <= '0;
            end else if (beep_inc) begin
                beep_cnt <= beep_cnt + BC_W'(1);
            end

            // Tone starts high on beep entry, then flips every TONE_HALF cycles.
            if (state_n != BEEP) begin
                piezo    <= 1'b0;
                tone_cnt <= '0;
            end else if (state != BEEP) begin
                piezo    <= 1'b1;
                tone_cnt <= '0;
            end else if (tone_cnt == TN_W'(TONE_HALF - 1)) begin
                piezo    <= ~piezo;
                tone_cnt <= '0;
            end else begin
                tone_cnt <= tone_cnt + TN_W'(1);
            end

            led  <= (state_n == BEEP);
            busy <= (state_n != IDLE);
        end
    end

    assign bus.PIEZO = piezo;
    assign bus.LED   = led;
    assign bus.BUSY  = busy;

endmodule

// File: tb/tb_timer_alarm_ctrl.sv
// Scoreboard bench for timer_alarm_ctrl: stimulus queues expectations per cycle.
// Optional feature macro: ALARM_TIMEOUT_EN (ring timeout of TIMEOUT_S seconds).
module tb_timer_alarm_ctrl;

    logic CLK;
    logic RESETN;
    int   cyc;
    int   total;
    int   bad;
    int   base;
    logic prev_piezo;

    timer_alarm_ctrl_if bus ();

    timer_alarm_ctrl #(
        .TONE_HALF(1),
        .BEEP_MS  (200),
        .GAP_MS   (100),
        .BEEPS    (4),
        .PAUSE_MS (500),
        .TIMEOUT_S(2)
    ) dut (
        .CLK   (CLK),
        .RESETN(RESETN),
        .bus   (bus)
    );

    typedef struct {
        int    cyc;
        int    kind;
        logic  busy;
        logic  led;
        logic  chk_p;
        logic  piezo;
        string name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not end, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // kind 0: exact busy/led (and piezo if chk_p); kind 1: piezo must flip
    task automatic push(input int c, input int k, input logic b,
                        input logic l, input logic cp, input logic p,
                        input string n);
        exp_t x;
        x.cyc = c; x.kind = k; x.busy = b; x.led = l;
        x.chk_p = cp; x.piezo = p; x.name = n;
        sb.push_back(x);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset(input logic s_level);
        RESETN   = 1'b0;
        bus.S    = s_level;
        bus.STOP = 1'b0;
        push(cyc, 0, 1'b0, 1'b0, 1'b1, 1'b0, "reset");
        repeat (3) @(posedge CLK);
        #1;
        RESETN = 1'b1;
        base   = cyc;
    endtask

    always @(negedge CLK) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d missed at %0d",
                         e.name, e.cyc, cyc);
            end else if (e.kind == 1) begin
                if (bus.PIEZO === prev_piezo || $isunknown(bus.PIEZO)) begin
                    bad++;
                    $display("FAIL %s: cyc %0d piezo=%b, required flip from %b",
                             e.name, cyc, bus.PIEZO, prev_piezo);
                end
            end else if (bus.BUSY !== e.busy || bus.LED !== e.led ||
                         (e.chk_p && bus.PIEZO !== e.piezo)) begin
                bad++;
                $display("FAIL %s: cyc %0d busy/led/piezo=%b%b%b required %b%b%s",
                         e.name, cyc, bus.BUSY, bus.LED, bus.PIEZO,
                         e.busy, e.led, e.chk_p ? (e.piezo ? "1" : "0") : "-");
            end
        end
        prev_piezo = bus.PIEZO;
    end

    initial begin
        cyc      = 0;
        total    = 0;
        bad      = 0;
        base     = 0;
        RESETN   = 1'b1;
        bus.S    = 1'b0;
        bus.STOP = 1'b0;
        @(posedge CLK);
        #1;

        // burst timing, pause, and timeout or endless ring
        do_reset(1'b0);
        push(base + 10, 0, 1'b0, 1'b0, 1'b1, 1'b0, "idle");
        push(base + 11, 0, 1'b1, 1'b1, 1'b0, 1'b0, "start");
        for (int k = 11; k <= 210; k++) begin
            push(base + k, 1, 1'b1, 1'b1, 1'b0, 1'b0, "tone");
        end
        push(base + 211,  0, 1'b1, 1'b0, 1'b1, 1'b0, "gap1_first");
        push(base + 260,  0, 1'b1, 1'b0, 1'b1, 1'b0, "gap1_mid");
        push(base + 310,  0, 1'b1, 1'b0, 1'b1, 1'b0, "gap1_last");
        push(base + 311,  0, 1'b1, 1'b1, 1'b0, 1'b0, "beep2");
        push(base + 1110, 0, 1'b1, 1'b1, 1'b0, 1'b0, "beep4_last");
        push(base + 1111, 0, 1'b1, 1'b0, 1'b1, 1'b0, "gap4");
        push(base + 1710, 0, 1'b1, 1'b0, 1'b1, 1'b0, "pause_last");
        push(base + 1711, 0, 1'b1, 1'b1, 1'b0, 1'b0, "beep5");
`ifdef ALARM_TIMEOUT_EN
        push(base + 2010, 0, 1'b1, 1'b0, 1'b0, 1'b0, "pre_timeout");
        push(base + 2011, 0, 1'b0, 1'b0, 1'b1, 1'b0, "timeout");
        push(base + 3000, 0, 1'b0, 1'b0, 1'b1, 1'b0, "no_rearm_to");
        push(base + 5000, 0, 1'b0, 1'b0, 1'b1, 1'b0, "idle_5000");
`else
        push(base + 5000, 0, 1'b1, 1'b0, 1'b1, 1'b0, "busy_5000");
`endif
        wait_cyc(base + 10);
        bus.S = 1'b1;
        wait_cyc(base + 5001);

        // stop mid-beep, no restart while S held, re-arm and S drop
        do_reset(1'b0);
        push(base + 11,   0, 1'b1, 1'b1, 1'b0, 1'b0, "start2");
        push(base + 350,  0, 1'b1, 1'b1, 1'b0, 1'b0, "beep2_pre_stop");
        push(base + 351,  0, 1'b0, 1'b0, 1'b1, 1'b0, "stop");
        push(base + 400,  0, 1'b0, 1'b0, 1'b1, 1'b0, "stop_held");
        push(base + 2350, 0, 1'b0, 1'b0, 1'b1, 1'b0, "no_restart");
        push(base + 2366, 0, 1'b1, 1'b1, 1'b0, 1'b0, "rearm");
        push(base + 2400, 0, 1'b1, 1'b1, 1'b0, 1'b0, "rearm_beep");
        push(base + 2401, 0, 1'b0, 1'b0, 1'b1, 1'b0, "s_drop");
        wait_cyc(base + 10);
        bus.S = 1'b1;
        wait_cyc(base + 350);
        bus.STOP = 1'b1;
        wait_cyc(base + 400);
        bus.STOP = 1'b0;
        wait_cyc(base + 2360);
        bus.S = 1'b0;
        wait_cyc(base + 2365);
        bus.S = 1'b1;
        wait_cyc(base + 2400);
        bus.S = 1'b0;
        wait_cyc(base + 2402);

        // S and STOP rising together: stop wins
        do_reset(1'b0);
        push(base + 11, 0, 1'b0, 1'b0, 1'b1, 1'b0, "tie_stop");
        push(base + 20, 0, 1'b0, 1'b0, 1'b1, 1'b0, "tie_after");
        wait_cyc(base + 10);
        bus.S    = 1'b1;
        bus.STOP = 1'b1;
        wait_cyc(base + 15);
        bus.STOP = 1'b0;
        wait_cyc(base + 21);

        // S high across reset release, then async reset mid-beep
        do_reset(1'b1);
        push(base + 1,  0, 1'b1, 1'b1, 1'b0, 1'b0, "s_at_release");
        push(base + 50, 0, 1'b0, 1'b0, 1'b1, 1'b0, "async_reset");
        wait_cyc(base + 50);
        #2;
        RESETN = 1'b0;
        wait_cyc(base + 52);
        RESETN = 1'b1;
        bus.S  = 1'b0;

        repeat (3) @(negedge CLK);
        if (sb.size() != 0) begin
            $display("FAIL leftover: %0d checks never reached, required 0",
                     sb.size());
            total += sb.size();
            bad   += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
